// File: rtl/score_display.sv
// Score readout: detects score changes, converts binary to BCD by sequential
// double-dabble (one shift per clock) and drives three seven-segment digits.
module score_display #(
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  score,
  output logic [11:0] bcd,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic        busy,
  output logic        done
);

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned SR_W    = SCORE_W + BCD_W;
  localparam int unsigned CNT_W   = 3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_POL   = SEG_ACTIVE_LOW ? 7'h00 : 7'h7f;
  localparam logic [6:0] HEX0_RST  = SEG_ZERO ^ SEG_POL;
  localparam logic [6:0] HEXL_RST  = (BLANK_LEADING ? SEG_BLANK : SEG_ZERO) ^ SEG_POL;

  typedef enum logic {IDLE, CONV} state_t;

  // Active-low g..a segment pattern for one decimal digit
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = SEG_BLANK;
    endcase
  endfunction

  state_t             state;
  logic [SCORE_W-1:0] last_score;
  logic [SR_W-1:0]    sr;
  logic [CNT_W-1:0]   cnt;

  logic [SR_W-1:0]    sr_adj;
  logic [SR_W-1:0]    sr_shift;
  logic [BCD_W-1:0]   bcd_nxt;
  logic               blank2;
  logic               blank1;
  logic [6:0]         hex0_nxt;
  logic [6:0]         hex1_nxt;
  logic [6:0]         hex2_nxt;

  // One double-dabble step plus the display image of the resulting digits
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (sr[SCORE_W + 4*i +: 4] >= 4'd5)
        sr_adj[SCORE_W + 4*i +: 4] = sr[SCORE_W + 4*i +: 4] + 4'd3;
    end
    sr_shift = {sr_adj[SR_W-2:0], 1'b0};
    bcd_nxt  = sr_shift[SR_W-1:SCORE_W];
    blank2   = BLANK_LEADING && (bcd_nxt[11:8] == 4'd0);
    blank1   = blank2 && (bcd_nxt[7:4] == 4'd0);
    hex2_nxt = (blank2 ? SEG_BLANK : seg_enc(bcd_nxt[11:8])) ^ SEG_POL;
    hex1_nxt = (blank1 ? SEG_BLANK : seg_enc(bcd_nxt[7:4])) ^ SEG_POL;
    hex0_nxt = seg_enc(bcd_nxt[3:0]) ^ SEG_POL;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_score <= '0;
      sr         <= '0;
      cnt        <= '0;
      bcd        <= '0;
      hex0       <= HEX0_RST;
      hex1       <= HEXL_RST;
      hex2       <= HEXL_RST;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (score != last_score) begin
            last_score <= score;
            sr         <= {BCD_W'(0), score};
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          sr  <= sr_shift;
          cnt <= cnt + CNT_W'(1);
          // Eighth shift completes the conversion
          if (cnt == CNT_W'(7)) begin
            bcd   <= bcd_nxt;
            hex0  <= hex0_nxt;
            hex1  <= hex1_nxt;
            hex2  <= hex2_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
